// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: DVI control tokens, their {c1,c0} codes and the
// word-aligner state encoding.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [1:0] CTRL_00 = 2'b00;
  localparam logic [1:0] CTRL_01 = 2'b01;
  localparam logic [1:0] CTRL_10 = 2'b10;
  localparam logic [1:0] CTRL_11 = 2'b11;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } aligner_state_t;

endpackage

// File: rtl/tmds_token_match.sv
// Combinational match of one 10-bit candidate against the four DVI control
// tokens; ctrl is the decoded {c1,c0} and is 0 when there is no hit.
module tmds_token_match
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       hit,
  output logic [1:0] ctrl
);

  always_comb begin
    hit  = 1'b1;
    ctrl = CTRL_00;
    case (word)
      CTRL_TOKEN_00: ctrl = CTRL_00;
      CTRL_TOKEN_01: ctrl = CTRL_01;
      CTRL_TOKEN_10: ctrl = CTRL_10;
      CTRL_TOKEN_11: ctrl = CTRL_11;
      default:       hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: hunts for control tokens at all ten bit offsets,
// locks on a stable offset and barrel-shifts the raw stream into symbols.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] raw_word,
  input  logic       raw_valid,
  output logic [9:0] aligned_word,
  output logic       aligned_valid,
  output logic       ctrl_valid,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  aligner_state_t    state, state_d;
  logic [9:0]        prev_word;
  logic [3:0]        cand, cand_d, cand_trk, offset_d;
  logic [RUN_W-1:0]  run_cnt, run_d, run_trk;
  logic [IDLE_W-1:0] idle_cnt, idle_d, idle_inc;
  logic              locked_d;

  // Stage p0: 20-bit window, parallel token search and aligned-symbol select
  logic [19:0] win_p0;
  logic [9:0]  hit_p0;
  logic [1:0]  ctrl_unused_p0 [10];
  logic [9:0]  align_p0;
  logic        align_hit_p0;
  logic [1:0]  align_ctrl_p0;
  logic [3:0]  first_p0;
  logic        any_hit_p0;

  assign win_p0     = {raw_word, prev_word};
  assign align_p0   = win_p0[offset +: 10];
  assign any_hit_p0 = |hit_p0;

  for (genvar k = 0; k < 10; k++) begin : g_match
    tmds_token_match u_match (
      .word (win_p0[k +: 10]),
      .hit  (hit_p0[k]),
      .ctrl (ctrl_unused_p0[k])
    );
  end

  tmds_token_match u_align_match (
    .word (align_p0),
    .hit  (align_hit_p0),
    .ctrl (align_ctrl_p0)
  );

  always_comb begin
    first_p0 = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit_p0[k]) first_p0 = 4'(k);
    end
  end

  // Candidate/run tracking shared by SEARCH and the relock path of LOCKED
  always_comb begin
    cand_trk = cand;
    run_trk  = run_cnt;
    idle_inc = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    if (!any_hit_p0) begin
      run_trk = '0;
    end else if (first_p0 == cand) begin
      run_trk = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    end else begin
      cand_trk = first_p0;
      run_trk  = RUN_W'(1);
    end
  end

  always_comb begin
    state_d  = state;
    cand_d   = cand;
    run_d    = run_cnt;
    idle_d   = idle_cnt;
    offset_d = offset;
    locked_d = locked;
    if (raw_valid) begin
      case (state)
        SEARCH: begin
          cand_d = cand_trk;
          run_d  = run_trk;
          if (run_trk == RUN_MAX) begin
            offset_d = cand_trk;
            locked_d = 1'b1;
            state_d  = LOCKED;
            idle_d   = '0;
          end
        end
        LOCKED: begin
          if (hit_p0[offset]) begin
            idle_d = '0;
            run_d  = '0;
          end else begin
            cand_d = cand_trk;
            run_d  = run_trk;
            idle_d = idle_inc;
            // A completed relock takes priority over a timeout on the same word
            if (run_trk == RUN_MAX) begin
              offset_d = cand_trk;
              idle_d   = '0;
            end else if (idle_inc == IDLE_MAX) begin
              locked_d = 1'b0;
              state_d  = SEARCH;
              run_d    = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Stage p1: registered state and aligned outputs
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEARCH;
      prev_word     <= '0;
      cand          <= '0;
      run_cnt       <= '0;
      idle_cnt      <= '0;
      offset        <= '0;
      locked        <= 1'b0;
      aligned_word  <= '0;
      aligned_valid <= 1'b0;
      ctrl_valid    <= 1'b0;
      ctrl          <= '0;
    end else begin
      state         <= state_d;
      cand          <= cand_d;
      run_cnt       <= run_d;
      idle_cnt      <= idle_d;
      offset        <= offset_d;
      locked        <= locked_d;
      aligned_valid <= raw_valid;
      ctrl_valid    <= raw_valid & align_hit_p0;
      if (raw_valid) begin
        prev_word    <= raw_word;
        aligned_word <= align_p0;
        if (align_hit_p0) ctrl <= align_ctrl_p0;
      end
    end
  end

endmodule
